// File: rtl/centroid_pkg.sv
// Shared widths, FSM encoding and the off-screen coordinate for the centroid tracker.
package centroid_pkg;
    localparam int COORD_W = 12;
    localparam int SUM_W   = 32;
    localparam int CNT_W   = 20;

    localparam logic [COORD_W-1:0] COORD_NONE = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        UPDATE
    } state_e;
endpackage

// File: rtl/seq_div.sv
// Restoring divider, one quotient bit per cycle. The start cycle already performs the
// first step, so 32 busy cycles end with done high; the quotient is registered at that edge.
module seq_div
    import centroid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);
    logic [SUM_W-1:0] quo_q, quo_d, cur_quo;
    logic [CNT_W-1:0] rem_q, rem_d, cur_rem;
    logic [CNT_W-1:0] dvs_q, dvs_d, cur_dvs;
    logic [4:0]       step_q, step_d;
    logic             busy_q, busy_d;
    logic [CNT_W:0]   trial, diff;
    logic             fits;

    always_comb begin
        cur_quo = start ? dividend : quo_q;
        cur_rem = start ? '0 : rem_q;
        cur_dvs = start ? divisor : dvs_q;
        trial   = {cur_rem, cur_quo[SUM_W-1]};
        diff    = trial - {1'b0, cur_dvs};
        fits    = (trial >= {1'b0, cur_dvs});

        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        step_d = step_q;
        busy_d = busy_q;
        if (start || busy_q) begin
            quo_d  = {cur_quo[SUM_W-2:0], fits};
            rem_d  = fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
            dvs_d  = cur_dvs;
            step_d = start ? 5'd1 : step_q + 5'd1;
            busy_d = start ? 1'b1 : (step_q != 5'd31);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (step_q == 5'd31);
    assign quotient = quo_q;
endmodule

// File: rtl/centroid_tracker.sv
// Per-frame mask centroid, divided during vertical blanking and held for the next frame.
// Optional build macro CENTROID_MIN_AREA_EN: frames with fewer than MIN_AREA pixels count as empty.
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int IMG_W    = 720,
    parameter int IMG_H    = 576,
    parameter int MIN_AREA = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [7:0]         mask,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               coord_valid,
    output logic               locked,
    output logic               overrun
);
    wire unused_hsync = hsync_in;

    state_e             state_q, state_d;
    logic               vsync_q;
    logic [COORD_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
    logic [COORD_W-1:0] qx_q, qx_d, x_q, x_d, y_q, y_d;
    logic               coord_valid_q, coord_valid_d;
    logic               locked_q, locked_d;
    logic               overrun_q, overrun_d;

    logic               frame_end, area_ok;
    logic               snap_en, drop, cap_qx, do_update, div_start;
    logic               div_busy, div_done;
    logic [SUM_W-1:0]   div_quo;

    assign frame_end = vsync_q && !vsync_in;

    // The accumulators are snapshotted at frame end, so judging them now equals judging the snapshot.
`ifdef CENTROID_MIN_AREA_EN
    assign area_ok = (cnt_q != '0) && (cnt_q >= CNT_W'(MIN_AREA));
`else
    localparam int unused_min_area = MIN_AREA;
    assign area_ok = (cnt_q != '0);
`endif

    seq_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ((state_q == DIV_X) ? snap_x_q : snap_y_q),
        .divisor  (snap_cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    wire unused_quo_hi = ^div_quo[SUM_W-1:COORD_W];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_end && area_ok) state_d = DIV_X;
            DIV_X:   if (div_done) state_d = DIV_Y;
            DIV_Y:   if (div_done) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_en   = frame_end && (state_q == IDLE);
        drop      = snap_en && !area_ok;
        overrun_d = frame_end && (state_q != IDLE);
        div_start = ((state_q == DIV_X) || (state_q == DIV_Y)) && !div_busy;
        // First DIV_Y cycle: the divider still holds the X quotient from the previous edge.
        cap_qx    = (state_q == DIV_Y) && !div_busy;
        do_update = (state_q == UPDATE);
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!vsync_in) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (de_in) begin
            if (h_cnt_q == COORD_W'(IMG_W - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == COORD_W'(IMG_H - 1)) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        if (frame_end) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
        end else if (de_in && (mask != 8'h00)) begin
            sum_x_d = sum_x_q + SUM_W'(h_cnt_q);
            sum_y_d = sum_y_q + SUM_W'(v_cnt_q);
            cnt_d   = cnt_q + 1'b1;
        end

        snap_x_d   = snap_en ? sum_x_q : snap_x_q;
        snap_y_d   = snap_en ? sum_y_q : snap_y_q;
        snap_cnt_d = snap_en ? cnt_q   : snap_cnt_q;

        qx_d          = cap_qx ? div_quo[COORD_W-1:0] : qx_q;
        x_d           = do_update ? qx_q : x_q;
        y_d           = do_update ? div_quo[COORD_W-1:0] : y_q;
        coord_valid_d = do_update;
        locked_d      = locked_q;
        if (do_update) locked_d = 1'b1;
        else if (drop) locked_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            cnt_q         <= '0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_cnt_q    <= '0;
            qx_q          <= '0;
            x_q           <= COORD_NONE;
            y_q           <= COORD_NONE;
            coord_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            vsync_q       <= vsync_in;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
            cnt_q         <= cnt_d;
            snap_x_q      <= snap_x_d;
            snap_y_q      <= snap_y_d;
            snap_cnt_q    <= snap_cnt_d;
            qx_q          <= qx_d;
            x_q           <= x_d;
            y_q           <= y_d;
            coord_valid_q <= coord_valid_d;
            locked_q      <= locked_d;
            overrun_q     <= overrun_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign coord_valid = coord_valid_q;
    assign locked      = locked_q;
    assign overrun     = overrun_q;
endmodule

// File: doc/centroid_tracker.md
# centroid_tracker

Frame-rate controller that produces the crosshair coordinates consumed by the overlay stage (`visualize`). It watches the same video timing and 8-bit mask stream, accumulates the coordinates of every non-zero mask pixel over a frame, and divides in vertical blanking to get the centroid. The resulting `x`/`y` are held stable for the whole next frame. It sits beside the overlay stage on the mask bus, with its `x`/`y` outputs wired to the overlay's `x`/`y` inputs.

## Interface
- IMG_W, 720: active pixels per line; must match the overlay stage.
- IMG_H, 576: active lines per frame; must match the overlay stage.
- MIN_AREA, 16: minimum pixel count for an update; used only with `CENTROID_MIN_AREA_EN`.
- clk  in  1  pixel clock, shared with the overlay stage.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- de_in  in  1  data enable.
- hsync_in  in  1  horizontal sync (unused internally; kept for bus symmetry).
- vsync_in  in  1  vertical sync; low = vertical blanking.
- mask  in  8  mask pixel; non-zero = object.
- x  out  12  centroid column; reset 12'hFFF.
- y  out  12  centroid row; reset 12'hFFF.
- coord_valid  out  1  one-cycle pulse when `x`/`y` are updated; reset 0.
- locked  out  1  level, 1 if the last completed frame updated `x`/`y`; reset 0.
- overrun  out  1  one-cycle pulse when a frame end is dropped; reset 0.

## Operation
- Pixel counters `h_cnt`/`v_cnt` (12 b) must count exactly as the overlay stage does, so coordinates align:
  - While `vsync_in`=0, both counters are 0.
  - Otherwise `h_cnt` increments when `de_in`=1.
  - When `h_cnt`==IMG_W-1, `h_cnt` goes to 0 and `v_cnt` increments; `v_cnt` wraps to 0 after IMG_H-1.
- Accumulate on `de_in`=1 and `mask`!=0:
  - `sum_x` += `h_cnt`, `sum_y` += `v_cnt`; both 32-bit unsigned.
  - `cnt` += 1; 20-bit unsigned. Max 414720 fits; no saturation needed.
- Frame end is edge cycle E, defined as registered `vsync_in`=1 and current `vsync_in`=0. At E:
  - Snapshot `sum_x`, `sum_y`, `cnt` into the divider operand registers.
  - Clear the accumulators, so the next frame accumulates concurrently.
- FSM states: IDLE, DIV_X, DIV_Y, UPDATE.
  - IDLE -> DIV_X at E+1 if the snapshot `cnt`!=0 (and `cnt`>=MIN_AREA when the macro is defined).
  - If that check fails, stay in IDLE: `x`/`y` hold, `locked`<=0, no `coord_valid`.
  - DIV_X: 32 cycles of restoring division, `sum_x`/`cnt`, floor quotient.
  - DIV_Y: 32 cycles, `sum_y`/`cnt`.
  - UPDATE: one cycle. Load `x`<=qx[11:0], `y`<=qy[11:0]; pulse `coord_valid`; set `locked`<=1; return to IDLE.
- Quotient is at most IMG_W-1 / IMG_H-1, so truncation to 12 b is lossless.
- Frame end while the FSM is not in IDLE: do not take the snapshot, but still clear the accumulators. Pulse `overrun`; the current division continues.
- `rst` at any cycle: FSM to IDLE, accumulators and counters cleared, `x`=`y`=12'hFFF (off-screen, so no crosshair is drawn), flags 0. An in-flight division is discarded with no pulse.
- A pixel on the E cycle itself cannot occur, since `vsync_in` is low; no special case is needed.

## Timing
- `x`/`y`/`coord_valid`/`locked` change at E+66 (E+1..E+32 DIV_X, E+33..E+64 DIV_Y, E+65 UPDATE, registered outputs visible at E+66).
- Vertical blanking must be at least 66 cycles; PAL blanking is far larger.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `CENTROID_MIN_AREA_EN` defined: frames with 0 < `cnt` < MIN_AREA are treated as empty. `x`/`y` hold and `locked`<=0.
- Not defined: any `cnt`>=1 updates; the MIN_AREA parameter is ignored.

## Structure
- Package `centroid_pkg` holds:
  - COORD_W=12, SUM_W=32, CNT_W=20.
  - FSM state enum.
  - COORD_NONE=12'hFFF.
- Sub-module `seq_div`: a restoring divider, SUM_W/CNT_W, with start/done handshake and one quotient bit per cycle. It is instantiated once and reused for X then Y.

## Test plan
- Single mask pixel at (100,50), then vsync falls -> at E+66 `x`=100, `y`=50, `coord_valid` pulses once, `locked`=1.
- 10x10 block at columns 200..209, rows 300..309 -> `x`=204, `y`=304 (floor of 204.5/304.5).
- Empty frame after a valid one -> `x`/`y` unchanged, no `coord_valid`, `locked`=0.
- `rst` asserted at E+20 -> `x`=`y`=12'hFFF next cycle, no `coord_valid`, FSM in IDLE. The next frame computes normally.
- Two vsync falling edges 40 cycles apart -> `overrun` pulses on the second edge, the first result still lands at E+66, and the second frame's accumulators are cleared.
- With `CENTROID_MIN_AREA_EN`, MIN_AREA=16: 15-pixel frame holds; 16-pixel frame updates.
